// File: rtl/init_pkg.sv
// rtl/init_pkg.sv - shared fill-mode and initialiser state types
package init_pkg;

    typedef enum logic [1:0] {
        IDENTITY   = 2'd0,
        CONST      = 2'd1,
        DESCENDING = 2'd2,
        RSVD       = 2'd3
    } init_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } init_state_t;

endpackage

// File: rtl/s_array_init_if.sv
// rtl/s_array_init_if.sv - RAM write port between initialiser and RAM/arbiter
interface s_array_init_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/init_addr_counter.sv
// rtl/init_addr_counter.sv - fill index counter, doubles as accepted-write count
module init_addr_counter #(
    parameter int W     = 9,
    parameter int DEPTH = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         advance,
    output logic [W-1:0] idx,
    output logic         last
);
    localparam logic [W-1:0] LAST_IDX = W'(DEPTH - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (advance) begin
            idx <= idx + W'(1);
        end
    end

    assign last = (idx == LAST_IDX);
endmodule

// File: rtl/s_array_init.sv
// rtl/s_array_init.sv - fills a RAM address range with identity, constant or descending data
module s_array_init
    import init_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              abort,
    s_array_init_if.master    wr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count
);
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

    init_state_t       state, state_nxt;
    init_mode_t        mode_q;
    logic [DATA_W-1:0] fill_q;
    logic [ADDR_W:0]   idx;
    logic [ADDR_W:0]   desc;
    logic              last;
    logic              start_acc;
    logic              accept;

    assign start_acc = (state == IDLE) && start;
    assign accept    = (state == FILL) && wr.wr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort takes priority over completion: an aborted fill never pulses done.
    always_comb begin
        state_nxt = state;
        wr.wr_en  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                wr.wr_en = 1'b1;
                busy     = 1'b1;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (accept && last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= IDENTITY;
            fill_q <= '0;
        end else if (start_acc) begin
            mode_q <= init_mode_t'(mode);
            fill_q <= fill_value;
        end
    end

    init_addr_counter #(
        .W     (ADDR_W + 1),
        .DEPTH (DEPTH)
    ) u_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_acc),
        .advance (accept),
        .idx     (idx),
        .last    (last)
    );

    // Data is a function of registered idx and mode only, so it holds while stalled.
    assign desc = LAST_IDX - idx;

    always_comb begin
        wr.wr_data = DATA_W'(idx);
        case (mode_q)
            CONST:      wr.wr_data = fill_q;
            DESCENDING: wr.wr_data = DATA_W'(desc);
            default:    wr.wr_data = DATA_W'(idx);
        endcase
    end

    assign wr.wr_addr = idx[ADDR_W-1:0];
    assign count      = idx;
endmodule

// File: tb/tb_s_array_init.sv
// tb/tb_s_array_init.sv - scoreboard bench for s_array_init at full-range narrow-data geometry
module tb_s_array_init;
    localparam int DATA_W = 3;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int BOUND  = 4 * DEPTH + 20;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [1:0]        mode;
    logic [DATA_W-1:0] fill_value;
    logic              abort;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   count;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int exp_addr[$];
    int exp_data[$];

    s_array_init_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wr_bus ();

    s_array_init #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .fill_value (fill_value),
        .abort      (abort),
        .wr         (wr_bus),
        .busy       (busy),
        .done       (done),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model(input logic [1:0] m, input int fv, input int i);
        int mask;
        mask = (1 << DATA_W) - 1;
        case (m)
            2'd1:    return fv & mask;
            2'd2:    return (DEPTH - 1 - i) & mask;
            default: return i & mask;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!reset && wr_bus.wr_en && wr_bus.wr_ready) begin
            if (exp_addr.size() == 0) begin
                check("extra_write", 32'(wr_bus.wr_addr) + 32'd1000, 32'd0);
            end else begin
                check("wr_addr", 32'(wr_bus.wr_addr), exp_addr.pop_front());
                check("wr_data", 32'(wr_bus.wr_data), exp_data.pop_front());
            end
        end
        if (!reset && done) n_done++;
    end

    // stall: 0 ready always, 1 toggling with stray starts, 2 random (plus abort beside start)
    task automatic run_fill(input logic [1:0] m, input int fv, input int stall, input int abort_at);
        int   n, acc, stalls, cyc, d0;
        logic rdy;
        n = (abort_at < 0) ? DEPTH : abort_at + 1;
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(i % (1 << ADDR_W));
            exp_data.push_back(model(m, fv, i));
        end
        d0         = n_done;
        start      = 1'b1;
        mode       = m;
        fill_value = DATA_W'(fv);
        abort      = (stall == 2);
        wr_ready_drive(1'b1);
        @(posedge clk); #1;
        start      = 1'b0;
        abort      = 1'b0;
        mode       = ~m;
        fill_value = ~fill_value;
        acc = 0; stalls = 0; cyc = 1;
        while (acc < n && cyc < BOUND) begin
            check("busy_fill", 32'(busy), 1);
            check("wr_en_fill", 32'(wr_bus.wr_en), 1);
            if (stall == 0)      rdy = 1'b1;
            else if (stall == 1) rdy = (cyc % 2 == 1);
            else                 rdy = ($urandom_range(0, 1) == 1);
            if (abort_at >= 0 && acc == abort_at) begin
                rdy   = 1'b1;
                abort = 1'b1;
            end
            start = (stall == 1);
            wr_ready_drive(rdy);
            if (rdy) acc++;
            else     stalls++;
            @(posedge clk); #1;
            cyc++;
            abort = 1'b0;
        end
        check("fill_bound", 32'(cyc < BOUND), 1);
        if (abort_at >= 0) begin
            start = 1'b0;
            check("abort_busy", 32'(busy), 0);
            check("abort_wr_en", 32'(wr_bus.wr_en), 0);
            check("abort_count", 32'(count), n);
            @(posedge clk); #1;
            check("abort_no_done", n_done - d0, 0);
            check("abort_count_hold", 32'(count), n);
        end else begin
            check("done_at_depth_plus_stalls", 32'(done), 1);
            check("done_busy", 32'(busy), 1);
            check("done_wr_en", 32'(wr_bus.wr_en), 0);
            check("done_count", 32'(count), DEPTH);
            @(posedge clk); #1;
            start = 1'b0;
            check("idle_done", 32'(done), 0);
            check("idle_busy", 32'(busy), 0);
            check("idle_count", 32'(count), DEPTH);
            check("one_done_pulse", n_done - d0, 1);
        end
        check("queue_empty", exp_addr.size(), 0);
        @(posedge clk); #1;
        check("idle_stays", 32'(busy), 0);
    endtask

    task automatic wr_ready_drive(input logic v);
        wr_bus.wr_ready = v;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},   32'(wr_bus.wr_en),   0);
        check({tag, "_wr_addr"}, 32'(wr_bus.wr_addr), 0);
        check({tag, "_wr_data"}, 32'(wr_bus.wr_data), 0);
        check({tag, "_busy"},    32'(busy),           0);
        check({tag, "_done"},    32'(done),           0);
        check({tag, "_count"},   32'(count),          0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        reset      = 1'b1;
        start      = 1'b0;
        mode       = 2'd0;
        fill_value = '0;
        abort      = 1'b0;
        wr_bus.wr_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        run_fill(2'd0, 0,    0, -1);
        run_fill(2'd1, 'hA5, 1, -1);
        run_fill(2'd2, 0,    2, -1);
        run_fill(2'd3, 'h3,  0, -1);
        run_fill(2'd0, 0,    0, 5);
        run_fill(2'd0, 0,    0, -1);
        run_fill(2'd2, 0,    1, 3);
        run_fill(2'd1, 'h2,  2, -1);

        d0 = n_done;
        for (int i = 0; i < 10; i++) begin
            exp_addr.push_back(i);
            exp_data.push_back(model(2'd2, 0, i));
        end
        start = 1'b1;
        mode  = 2'd2;
        wr_bus.wr_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("pre_reset_count", 32'(count), 10);
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        check("mid_reset_queue", exp_addr.size(), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("no_resume_busy", 32'(busy), 0);
        check("no_resume_done", n_done - d0, 0);

        run_fill(2'd0, 0, 1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
